sram_arb_ctrl: RTL

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

---
 rtl/sram_arb_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter in front of a single-port synchronous SRAM: zero-fills the
// array after reset, then grants one request per cycle with alternating priority.
module sram_arb_ctrl #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 7,
    parameter int DEPTH   = 128,
    parameter int INIT_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_i,
    input  logic [DATA_W-1:0]     sram_o,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One extra count past the last address marks the cycle the final fill write
    // is on the pins, so RUN starts on the edge that retires it.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH);
    localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic RST_DONE = (INIT_EN != 0) ? 1'b0 : 1'b1;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                init_done_r, init_done_s;
    logic                last_grant_r, last_grant_s;
    logic [1:0]          gnt_s;
    logic                gnt_idx_s;
    logic [ADDR_W-1:0]   gnt_addr_s;

    logic                sram_csb_r, csb_s;
    logic                sram_web_r, web_s;
    logic                sram_oeb_r, oeb_s;
    logic [ADDR_W-1:0]   sram_a_r, a_s;
    logic [DATA_W-1:0]   sram_i_r, i_s;

    logic                rd_v_s, rd_p_s;
    logic                rd1_v_r, rd1_p_r;
    logic [1:0]          rsp_valid_r;

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr);
        return ADDR_W'(int'(addr) % DEPTH);
    endfunction

    // Next-state, grant selection and next SRAM pin values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        init_done_s  = init_done_r;
        last_grant_s = last_grant_r;
        gnt_s        = 2'b00;
        gnt_idx_s    = 1'b0;
        gnt_addr_s   = {ADDR_W{1'b0}};
        csb_s        = 1'b1;
        web_s        = 1'b1;
        oeb_s        = 1'b1;
        a_s          = sram_a_r;
        i_s          = sram_i_r;
        rd_v_s       = 1'b0;
        rd_p_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s     = ST_RUN;
                    init_done_s = 1'b1;
                end else begin
                    csb_s = 1'b0;
                    web_s = 1'b0;
                    a_s   = cnt_r[ADDR_W-1:0];
                    i_s   = {DATA_W{1'b0}};
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (init_done_r) begin
                    case (req_valid)
                        2'b01:   gnt_s = 2'b01;
                        2'b10:   gnt_s = 2'b10;
                        2'b11:   gnt_s = last_grant_r ? 2'b01 : 2'b10;
                        default: gnt_s = 2'b00;
                    endcase
                end else begin
                    gnt_s = 2'b00;
                end
                gnt_idx_s  = gnt_s[1];
                gnt_addr_s = gnt_idx_s ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                if (gnt_s != 2'b00) begin
                    last_grant_s = gnt_idx_s;
                    csb_s        = 1'b0;
                    a_s          = wrap_addr(gnt_addr_s);
                    if (req_we[gnt_idx_s]) begin
                        web_s = 1'b0;
                        i_s   = gnt_idx_s ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                    end else begin
                        oeb_s  = 1'b0;
                        rd_v_s = 1'b1;
                        rd_p_s = gnt_idx_s;
                    end
                end else begin
                    csb_s = 1'b1;
                end
            end
            default: begin
                state_s = RST_STATE;
            end
        endcase
    end

    // Control state: FSM, fill counter, init flag and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RST_STATE;
            cnt_r        <= {CNT_W{1'b0}};
            init_done_r  <= RST_DONE;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            init_done_r  <= init_done_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Registered SRAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb_r <= 1'b1;
            sram_web_r <= 1'b1;
            sram_oeb_r <= 1'b1;
            sram_a_r   <= {ADDR_W{1'b0}};
            sram_i_r   <= {DATA_W{1'b0}};
        end else begin
            sram_csb_r <= csb_s;
            sram_web_r <= web_s;
            sram_oeb_r <= oeb_s;
            sram_a_r   <= a_s;
            sram_i_r   <= i_s;
        end
    end

    // In-flight read tracking: stage 1 covers the pin cycle, stage 2 the data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_v_r     <= 1'b0;
            rd1_p_r     <= 1'b0;
            rsp_valid_r <= 2'b00;
        end else begin
            rd1_v_r     <= rd_v_s;
            rd1_p_r     <= rd_p_s;
            rsp_valid_r <= rd1_v_r ? (rd1_p_r ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign req_ready = gnt_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = sram_o;
    assign init_done = init_done_r;
    assign sram_csb  = sram_csb_r;
    assign sram_web  = sram_web_r;
    assign sram_oeb  = sram_oeb_r;
    assign sram_a    = sram_a_r;
    assign sram_i    = sram_i_r;

endmodule
